// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter granting two requesters read bursts to one shared memory.
// Latency: grant and first read 1 cycle after request is sampled in IDLE; data 1 cycle after each read.
// Backpressure: none; requests are held until granted and are ignored while a burst is in progress.
module mem_read_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iReqA,
  input  logic              iReqB,
  input  logic [ADDR_W-1:0] iAddrA,
  input  logic [ADDR_W-1:0] iAddrB,
  input  logic [ADDR_W-1:0] iLenA,
  input  logic [ADDR_W-1:0] iLenB,
  output logic              oMemRd,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oGntA,
  output logic              oGntB,
  output logic              oValidA,
  output logic              oValidB,
  output logic              oDoneA,
  output logic              oDoneB,
  output logic [DATA_W-1:0] oData,
  output logic              oBusy
);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_own_b, w_own_b_nxt;     // current burst owner: 1 = B
  logic                r_last_b, w_last_b_nxt;   // last served requester: 1 = B
  logic [ADDR_W-1:0]   r_len, w_len_nxt;
  logic [ADDR_W:0]     r_cnt, w_cnt_nxt;         // reads issued so far; one bit wider so len=max fits
  logic                r_mem_rd, w_mem_rd_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                r_gnt_a, w_gnt_a_nxt;
  logic                r_gnt_b, w_gnt_b_nxt;
  logic                r_valid_a, w_valid_a_nxt;
  logic                r_valid_b, w_valid_b_nxt;
  logic                r_done_a, w_done_a_nxt;
  logic                r_done_b, w_done_b_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_pick_b;
  logic [ADDR_W:0]     w_len_p1;
  logic                w_last_rd;

  // Tie goes to whichever requester was not served last.
  assign w_pick_b  = iReqB & (~iReqA | ~r_last_b);
  assign w_len_p1  = {1'b0, r_len} + (ADDR_W+1)'(1);
  // True in the READ cycle presenting the final read of the burst.
  assign w_last_rd = (r_state == READ) && (r_cnt == w_len_p1);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_own_b_nxt    = r_own_b;
    w_last_b_nxt   = r_last_b;
    w_len_nxt      = r_len;
    w_cnt_nxt      = r_cnt;
    w_mem_rd_nxt   = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_gnt_a_nxt    = 1'b0;
    w_gnt_b_nxt    = 1'b0;
    // Memory returns data one cycle after each strobe, so valid trails the strobe.
    w_valid_a_nxt  = r_mem_rd & ~r_own_b;
    w_valid_b_nxt  = r_mem_rd &  r_own_b;
    w_done_a_nxt   = w_last_rd & ~r_own_b;
    w_done_b_nxt   = w_last_rd &  r_own_b;

    case (r_state)
      IDLE: begin
        if (iReqA || iReqB) begin
          w_state_nxt    = READ;
          w_own_b_nxt    = w_pick_b;
          w_last_b_nxt   = w_pick_b;
          w_len_nxt      = w_pick_b ? iLenB : iLenA;
          w_mem_addr_nxt = w_pick_b ? iAddrB : iAddrA;
          w_mem_rd_nxt   = 1'b1;
          w_cnt_nxt      = (ADDR_W+1)'(1);
          w_gnt_a_nxt    = ~w_pick_b;
          w_gnt_b_nxt    = w_pick_b;
        end
      end
      READ: begin
        if (w_last_rd) begin
          w_state_nxt = WAIT;
        end else begin
          w_mem_rd_nxt   = 1'b1;
          w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
          w_cnt_nxt      = r_cnt + (ADDR_W+1)'(1);
        end
      end
      WAIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers; reset abandons any burst in progress.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state    <= IDLE;
      r_own_b    <= 1'b0;
      r_last_b   <= 1'b1;
      r_len      <= '0;
      r_cnt      <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_valid_a  <= 1'b0;
      r_valid_b  <= 1'b0;
      r_done_a   <= 1'b0;
      r_done_b   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_own_b    <= w_own_b_nxt;
      r_last_b   <= w_last_b_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_gnt_a    <= w_gnt_a_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_valid_a  <= w_valid_a_nxt;
      r_valid_b  <= w_valid_b_nxt;
      r_done_a   <= w_done_a_nxt;
      r_done_b   <= w_done_b_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign oMemRd   = r_mem_rd;
  assign oMemAddr = r_mem_addr;
  assign oGntA    = r_gnt_a;
  assign oGntB    = r_gnt_b;
  assign oValidA  = r_valid_a;
  assign oValidB  = r_valid_b;
  assign oDoneA   = r_done_a;
  assign oDoneB   = r_done_b;
  assign oBusy    = r_busy;
  assign oData    = iMemData;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a one-cycle-latency memory model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; requests are driven directly by the bench.
module tb_mem_read_arbiter;

  logic       iClk;
  logic       iRst_n;
  logic       iReqA, iReqB;
  logic [3:0] iAddrA, iAddrB, iLenA, iLenB;
  logic       oMemRd;
  logic [3:0] oMemAddr;
  logic [7:0] iMemData;
  logic       oGntA, oGntB, oValidA, oValidB, oDoneA, oDoneB, oBusy;
  logic [7:0] oData;

  int n_checks = 0;
  int n_fail   = 0;

  mem_read_arbiter #(.DATA_W(8), .ADDR_W(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iReqA(iReqA), .iReqB(iReqB),
    .iAddrA(iAddrA), .iAddrB(iAddrB),
    .iLenA(iLenA), .iLenB(iLenB),
    .oMemRd(oMemRd), .oMemAddr(oMemAddr), .iMemData(iMemData),
    .oGntA(oGntA), .oGntB(oGntB),
    .oValidA(oValidA), .oValidB(oValidB),
    .oDoneA(oDoneA), .oDoneB(oDoneB),
    .oData(oData), .oBusy(oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Memory contents: word at address a is 0x50 + 3*a.
  function automatic logic [7:0] memval(input logic [3:0] a);
    return 8'(8'h50 + 8'(a) * 8'd3);
  endfunction

  // Memory answers one cycle after each read strobe.
  always @(posedge iClk) begin
    if (oMemRd) iMemData <= memval(oMemAddr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rd"},   32'(oMemRd),   0);
    chk({tag, ".addr"}, 32'(oMemAddr), 0);
    chk({tag, ".gnt"},  32'({oGntA, oGntB}), 0);
    chk({tag, ".vld"},  32'({oValidA, oValidB}), 0);
    chk({tag, ".done"}, 32'({oDoneA, oDoneB}), 0);
    chk({tag, ".busy"}, 32'(oBusy), 0);
  endtask

  // Entered in the grant cycle; walks the burst, WAIT, and the following IDLE cycle.
  // b_mode: 0 leave B alone, 1 pulse B mid-burst, 2 raise and hold B mid-burst.
  task automatic run_burst(input bit own_b, input logic [3:0] start, input logic [3:0] len,
                           input int b_mode);
    int ln;
    logic [3:0] a;
    bit v;
    string t;
    ln = int'(len);
    for (int k = 0; k <= ln + 2; k++) begin
      t = $sformatf("b%0d_s%0h_l%0d_k%0d", own_b, start, ln, k);
      a = start + 4'(k);
      v = (k >= 1) && (k <= ln + 1);
      chk({t, ".rd"},   32'(oMemRd), 32'(k <= ln));
      if (k <= ln) chk({t, ".addr"}, 32'(oMemAddr), 32'(a));
      chk({t, ".gntA"}, 32'(oGntA), 32'((k == 0) && !own_b));
      chk({t, ".gntB"}, 32'(oGntB), 32'((k == 0) && own_b));
      chk({t, ".vldA"}, 32'(oValidA), 32'(v && !own_b));
      chk({t, ".vldB"}, 32'(oValidB), 32'(v && own_b));
      chk({t, ".doneA"}, 32'(oDoneA), 32'((k == ln + 1) && !own_b));
      chk({t, ".doneB"}, 32'(oDoneB), 32'((k == ln + 1) && own_b));
      chk({t, ".busy"}, 32'(oBusy), 32'(k <= ln + 1));
      if (v) chk({t, ".data"}, 32'(oData), 32'(memval(start + 4'(k - 1))));
      if (b_mode != 0 && k == 1) begin
        iReqB  = 1'b1;
        iAddrA = 4'h9;
        iLenA  = 4'h0;
      end
      if (b_mode == 1 && k == 2) iReqB = 1'b0;
      if (k < ln + 2) tick();
    end
  endtask

  initial begin
    iRst_n = 1'b0;
    iReqA = 1'b0; iReqB = 1'b0;
    iAddrA = '0; iAddrB = '0; iLenA = '0; iLenB = '0;
    iMemData = '0;

    // Reset state
    #3;
    check_zero("rst0");
    repeat (2) @(posedge iClk);
    #1;
    check_zero("rst1");
    iRst_n = 1'b1;
    tick();
    check_zero("idle");

    // Single burst: A, addr 3, len 2
    iReqA = 1'b1; iAddrA = 4'd3; iLenA = 4'd2;
    tick();
    iReqA = 1'b0;
    run_burst(1'b0, 4'd3, 4'd2, 0);

    // Wrap: B, addr 14, len 3 -> 14,15,0,1
    iReqB = 1'b1; iAddrB = 4'd14; iLenB = 4'd3;
    tick();
    iReqB = 1'b0;
    run_burst(1'b1, 4'd14, 4'd3, 0);

    // Max length: A, addr 0, len 15
    iReqA = 1'b1; iAddrA = 4'd0; iLenA = 4'd15;
    tick();
    iReqA = 1'b0;
    run_burst(1'b0, 4'd0, 4'd15, 0);

    // Ignored inputs: A's addr/len change and a B pulse during A's burst
    iAddrB = 4'd7; iLenB = 4'd1;
    iReqA = 1'b1; iAddrA = 4'd5; iLenA = 4'd3;
    tick();
    iReqA = 1'b0;
    run_burst(1'b0, 4'd5, 4'd3, 1);
    tick();
    chk("pulse_b.gntB", 32'(oGntB), 0);
    chk("pulse_b.busy", 32'(oBusy), 0);

    // B raised mid-burst and held: granted once IDLE samples it
    iReqA = 1'b1; iAddrA = 4'd5; iLenA = 4'd3;
    tick();
    iReqA = 1'b0;
    run_burst(1'b0, 4'd5, 4'd3, 2);
    tick();
    iReqB = 1'b0;
    run_burst(1'b1, 4'd7, 4'd1, 0);

    // Reset mid-burst during the 2nd read of a len 5 burst
    iReqA = 1'b1; iAddrA = 4'd2; iLenA = 4'd5;
    tick();
    iReqA = 1'b0;
    chk("mid.rd0",   32'(oMemRd), 1);
    chk("mid.addr0", 32'(oMemAddr), 2);
    tick();
    chk("mid.rd1",   32'(oMemRd), 1);
    chk("mid.addr1", 32'(oMemAddr), 3);
    chk("mid.vld1",  32'(oValidA), 1);
    #2;
    iRst_n = 1'b0;
    iReqA = 1'b1; iAddrA = 4'd8;  iLenA = 4'd0;
    iReqB = 1'b1; iAddrB = 4'd12; iLenB = 4'd0;
    #1;
    check_zero("mid_rst_async");
    repeat (3) @(posedge iClk);
    #1;
    check_zero("mid_rst_held");
    iRst_n = 1'b1;

    // Tie after reset: A first, then B after one IDLE cycle
    tick();
    iReqA = 1'b0;
    run_burst(1'b0, 4'd8, 4'd0, 0);
    tick();
    iReqB = 1'b0;
    run_burst(1'b1, 4'd12, 4'd0, 0);

    // Tie again after B was served: A wins
    iReqA = 1'b1; iReqB = 1'b1;
    tick();
    iReqA = 1'b0; iReqB = 1'b0;
    run_burst(1'b0, 4'd8, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
